fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Takes pc_current, issues one read per instruction word to instruction memory over a req/gnt + rvalid handshake, and buffers returned words with their PC in a small FIFO for the decoder.
- Generates the single-cycle pc_step strobe that drives the PC's mem_ready input.
- Handles branch flushes: drops the buffered and in-flight fetch, and lets the PC load branch_addr.

---
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding read to instruction memory, with returned
// words buffered alongside their PC in a small FIFO for the decoder.
module fetch_unit #(
  parameter int DEPTH = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_current,
  output logic          pc_step,
  input  logic          flush,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state;
  state_t        next_state;
  logic [AW-1:0] addr_q;
  logic          req_q;
  logic          capture;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after_pop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] pc_mem   [DEPTH];

  assign instr_valid     = (count != {CW{1'b0}});
  assign pop             = instr_valid & instr_ready & ~flush;
  assign push            = (state == WAIT) & mem_rvalid & ~flush;
  assign count_after_pop = count - CW'(pop);
  // Gated by reset so the PC sees no strobe while the fetch stage is held in reset.
  assign pc_step         = rst & (push | flush);
  assign mem_req         = req_q;
  assign mem_addr        = addr_q;
  assign instr_data      = data_mem[rd_ptr];
  assign instr_pc        = pc_mem[rd_ptr];

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush && (count_after_pop < DEPTH_C)) begin
          next_state = REQ;
          capture    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          next_state = flush ? DRAIN : WAIT;
        end else if (flush) begin
          next_state = IDLE;
        end else begin
          next_state = REQ;
        end
      end
      WAIT: begin
        if (flush) begin
          next_state = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      // Any response arriving here belongs to a flushed fetch; drop it and resume.
      DRAIN: begin
        if (mem_rvalid) begin
          next_state = IDLE;
        end else begin
          next_state = DRAIN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      req_q  <= 1'b0;
      addr_q <= {AW{1'b0}};
    end else begin
      state <= next_state;
      req_q <= (next_state == REQ);
      if (capture) begin
        addr_q <= pc_current;
      end else begin
        addr_q <= addr_q;
      end
    end
  end

  // Flush wins over any same-cycle push or pop and leaves the FIFO empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= {DW{1'b0}};
        pc_mem[i]   <= {AW{1'b0}};
      end
    end else if (flush) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= mem_rdata;
        pc_mem[wr_ptr]   <= addr_q;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small PC model and a fixed-latency memory responder.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] pc;
  logic        pc_step;
  logic        flush;
  logic [15:0] branch_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;

  logic        gnt_en;
  int          lat;
  logic        rv_force;
  logic [15:0] force_data;
  int          pend_cnt;
  logic [15:0] pend_data;
  int          n_tests;
  int          n_fail;

  fetch_unit #(.DEPTH(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst), .pc_current(pc), .pc_step(pc_step), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_gnt    = gnt_en;
  assign mem_rvalid = (pend_cnt == 1) | rv_force;
  assign mem_rdata  = rv_force ? force_data : pend_data;

  // Memory: data = addr ^ 0xA5A5, returned lat cycles after the grant.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_cnt  <= 0;
      pend_data <= 16'h0000;
    end else if (mem_req && mem_gnt) begin
      pend_cnt  <= lat;
      pend_data <= mem_addr ^ 16'hA5A5;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  // Program counter: increments on pc_step, loads branch_addr when flushing.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc <= 16'h0000;
    else if (pc_step) pc <= flush ? branch_addr : pc + 16'd1;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic g, input int l);
    rst = 1'b0; flush = 1'b0; instr_ready = 1'b0; rv_force = 1'b0;
    gnt_en = g; lat = l; branch_addr = 16'h0000;
    cyc(); cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b1;
    #1;
    n_tests++;
    if ({mem_req, mem_addr, pc_step, instr_valid, instr_data, instr_pc} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b addr=%h step=%b valid=%b data=%h pc=%h, need all 0",
               mem_req, mem_addr, pc_step, instr_valid, instr_data, instr_pc);
    end
    flush = 1'b0;
  endtask

  task automatic test_basic();
    do_reset(1'b1, 1);
    cyc();
    n_tests++;
    if ({mem_req, mem_addr, pc_step} !== {1'b1, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL basic_req0: req=%b addr=%h step=%b, need 1 0000 0", mem_req, mem_addr, pc_step);
    end
    cyc();
    n_tests++;
    if ({mem_req, pc_step, instr_valid} !== 3'b010) begin
      n_fail++; $display("FAIL basic_step: req=%b step=%b valid=%b, need 0 1 0", mem_req, pc_step, instr_valid);
    end
    cyc();
    n_tests++;
    if ({instr_valid, instr_data, instr_pc, mem_req} !== {1'b1, 16'hA5A5, 16'h0000, 1'b0}) begin
      n_fail++; $display("FAIL basic_head: valid=%b data=%h pc=%h req=%b, need 1 a5a5 0000 0",
                         instr_valid, instr_data, instr_pc, mem_req);
    end
    cyc();
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0001}) begin
      n_fail++; $display("FAIL basic_req1: req=%b addr=%h, need 1 0001", mem_req, mem_addr);
    end
  endtask

  // Continues from test_basic: second word lands, FIFO full, fetching stops.
  task automatic test_fifo_full();
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if ({mem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 16'h0000}) begin
        n_fail++; $display("FAIL full_hold%0d: req=%b valid=%b pc=%h, need 0 1 0000", i, mem_req, instr_valid, instr_pc);
      end
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    n_tests++;
    if ({instr_pc, instr_data, mem_req, mem_addr} !== {16'h0001, 16'hA5A4, 1'b1, 16'h0002}) begin
      n_fail++; $display("FAIL full_pop: pc=%h data=%h req=%b addr=%h, need 0001 a5a4 1 0002",
                         instr_pc, instr_data, mem_req, mem_addr);
    end
    cyc(); cyc();
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    n_tests++;
    if ({instr_valid, instr_pc, instr_data} !== {1'b1, 16'h0002, 16'hA5A7}) begin
      n_fail++; $display("FAIL full_order: valid=%b pc=%h data=%h, need 1 0002 a5a7", instr_valid, instr_pc, instr_data);
    end
  endtask

  task automatic test_gnt_stall();
    do_reset(1'b0, 2);
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_tests++;
      if ({mem_req, mem_addr, pc_step} !== {1'b1, 16'h0000, 1'b0}) begin
        n_fail++; $display("FAIL stall%0d: req=%b addr=%h step=%b, need 1 0000 0", i, mem_req, mem_addr, pc_step);
      end
    end
    gnt_en = 1'b1;
    cyc();
    n_tests++;
    if ({mem_req, pc_step} !== 2'b00) begin
      n_fail++; $display("FAIL stall_wait: req=%b step=%b, need 0 0", mem_req, pc_step);
    end
    cyc();
    n_tests++;
    if (pc_step !== 1'b1) begin
      n_fail++; $display("FAIL stall_step: step=%b, need 1", pc_step);
    end
  endtask

  task automatic test_flush_wait();
    do_reset(1'b1, 4);
    cyc(); cyc();
    flush = 1'b1; branch_addr = 16'h0040;
    #1;
    n_tests++;
    if (pc_step !== 1'b1) begin
      n_fail++; $display("FAIL fw_step: step=%b, need 1", pc_step);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      flush = 1'b0;
      #1;
      n_tests++;
      if ({pc_step, mem_req} !== 2'b00) begin
        n_fail++; $display("FAIL fw_drain%0d: step=%b req=%b rvalid=%b, need step 0 req 0", i, pc_step, mem_req, mem_rvalid);
      end
    end
    cyc();
    n_tests++;
    if ({instr_valid, mem_req} !== 2'b00) begin
      n_fail++; $display("FAIL fw_empty: valid=%b req=%b, need 0 0", instr_valid, mem_req);
    end
    cyc();
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0040}) begin
      n_fail++; $display("FAIL fw_target: req=%b addr=%h, need 1 0040", mem_req, mem_addr);
    end
  endtask

  task automatic test_flush_rvalid();
    int steps;
    do_reset(1'b1, 1);
    for (int i = 0; i < 5; i++) cyc();
    flush = 1'b1; branch_addr = 16'h0080; instr_ready = 1'b1;
    #1;
    steps = int'(pc_step);
    cyc();
    flush = 1'b0; instr_ready = 1'b0;
    #1;
    steps += int'(pc_step);
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL fr_empty: valid=%b, need 0", instr_valid);
    end
    cyc();
    steps += int'(pc_step);
    n_tests++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0080}) begin
      n_fail++; $display("FAIL fr_target: req=%b addr=%h, need 1 0080", mem_req, mem_addr);
    end
    n_tests++;
    if (steps != 1) begin
      n_fail++; $display("FAIL fr_steps: pc_step count=%0d, need 1", steps);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1, 3);
    for (int i = 0; i < 9; i++) cyc();
    n_tests++;
    if ({pc_step, instr_valid} !== 2'b11) begin
      n_fail++; $display("FAIL rm_pre: step=%b valid=%b, need 1 1", pc_step, instr_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({mem_req, instr_valid, pc_step, instr_data} !== {3'b000, 16'h0000}) begin
      n_fail++; $display("FAIL rm_async: req=%b valid=%b step=%b data=%h, need 0 0 0 0000",
                         mem_req, instr_valid, pc_step, instr_data);
    end
    gnt_en = 1'b0;
    cyc();
    rst = 1'b1;
    cyc(); cyc();
    rv_force = 1'b1; force_data = 16'hBEEF;
    #1;
    n_tests++;
    if (pc_step !== 1'b0) begin
      n_fail++; $display("FAIL rm_late_step: step=%b, need 0", pc_step);
    end
    cyc();
    rv_force = 1'b0;
    n_tests++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL rm_late_push: valid=%b, need 0", instr_valid);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b0; flush = 1'b0; instr_ready = 1'b0; rv_force = 1'b0;
    force_data = 16'h0000; gnt_en = 1'b1; lat = 1; branch_addr = 16'h0000;
    cyc();
    test_reset();
    test_basic();
    test_fifo_full();
    test_gnt_stall();
    test_flush_wait();
    test_flush_rvalid();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
